ps2_keyboard_rx: RTL and testbench

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

---
 rtl/ps2_keyboard_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the pad signals, deframes
// 11-bit frames and decodes left/right arrow and space into held key levels.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire
);

    localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int unsigned TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W  = 3;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_FIRE  = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Synchronizers
    logic clk_meta_q, clk_sync_q;
    logic dat_meta_q, dat_sync_q;

    // Glitch filter on the synchronized clock
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_q, fall_d;

    // Receive FSM
    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TOUT_W-1:0] tout_q, tout_d;

    // Decoder and outputs
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] scan_q, scan_d;
    logic       cv_q, cv_d;
    logic       fe_q, fe_d;
    logic       left_q, left_d;
    logic       right_q, right_d;
    logic       fire_q, fire_d;
    logic       byte_ok_c;

    // A level change is accepted on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    // Frame FSM, timeout supervision and key decoder.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tout_d    = tout_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        scan_d    = scan_q;
        cv_d      = 1'b0;
        fe_d      = 1'b0;
        left_d    = left_q;
        right_d   = right_q;
        fire_d    = fire_q;
        byte_ok_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall_q && !dat_sync_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(7)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_q) begin
                    par_d   = dat_sync_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_q) begin
                    state_d = ST_IDLE;
                    if (dat_sync_q && (^{shift_q, par_q})) begin
                        byte_ok_c = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && !fall_q && (tout_q >= TOUT_W'(TIMEOUT_CYCLES - 1))) begin
            state_d = ST_IDLE;
            fe_d    = 1'b1;
        end

        if ((state_d == ST_IDLE) || fall_q) begin
            tout_d = '0;
        end else if (tout_q != TOUT_W'(TIMEOUT_CYCLES)) begin
            tout_d = tout_q + TOUT_W'(1);
        end

        if (byte_ok_c) begin
            cv_d   = 1'b1;
            scan_d = shift_q;
            if (shift_q == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == CODE_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q && (shift_q == CODE_LEFT)) begin
                    left_d = !brk_q;
                end
                if (ext_q && (shift_q == CODE_RIGHT)) begin
                    right_d = !brk_q;
                end
                if (!ext_q && (shift_q == CODE_FIRE)) begin
                    fire_d = !brk_q;
                end
            end
        end

        if (fe_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tout_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            scan_q     <= '0;
            cv_q       <= 1'b0;
            fe_q       <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            fire_q     <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tout_q     <= tout_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            scan_q     <= scan_d;
            cv_q       <= cv_d;
            fe_q       <= fe_d;
            left_q     <= left_d;
            right_q    <= right_d;
            fire_q     <= fire_d;
        end
    end

    assign scan_code  = scan_q;
    assign code_valid = cv_q;
    assign frame_err  = fe_q;
    assign key_left   = left_q;
    assign key_right  = right_q;
    assign key_fire   = fire_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomized bench for ps2_keyboard_rx against a frame-level keyboard model.
module tb_ps2_keyboard_rx;

    localparam int unsigned FL = 4;
    localparam int unsigned TO = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, frame_err, key_left, key_right, key_fire;

    int n_tests = 0;
    int n_fail  = 0;
    int cv_cnt  = 0;
    int fe_cnt  = 0;

    // Reference keyboard state
    logic [7:0] m_scan = 8'h00;
    logic m_ext = 1'b0, m_brk = 1'b0;
    logic m_left = 1'b0, m_right = 1'b0, m_fire = 1'b0;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .board_clk (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_dat),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .key_left  (key_left),
        .key_right (key_right),
        .key_fire  (key_fire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor: counts pulses and checks they never coincide.
    always @(negedge clk) begin
        if (code_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if (code_valid || frame_err) check("pulse_excl", 32'(code_valid & frame_err), 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            tick(10);
            ps2_clk = 1'b0;
            tick(20);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic good);
        if (!good) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_scan = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                if (m_ext && b == 8'h6B) m_left = !m_brk;
                if (m_ext && b == 8'h74) m_right = !m_brk;
                if (!m_ext && b == 8'h29) m_fire = !m_brk;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_scan"}, 32'(scan_code), 32'(m_scan));
        check({tag, "_keys"}, 32'({key_left, key_right, key_fire}), 32'({m_left, m_right, m_fire}));
    endtask

    task automatic do_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        int cv0, fe0;
        logic good;
        logic [10:0] bits;
        cv0  = cv_cnt;
        fe0  = fe_cnt;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        good = !bad_par && !bad_stop;
        send_bits(bits, 11);
        tick(40);
        model_byte(b, good);
        check("cv_pulses", 32'(cv_cnt - cv0), 32'(good));
        check("fe_pulses", 32'(fe_cnt - fe0), 32'(!good));
        check_outputs("frame");
    endtask

    task automatic reset_model();
        m_scan = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
        m_left = 1'b0; m_right = 1'b0; m_fire = 1'b0;
    endtask

    initial begin
        int cv0, fe0;
        logic [10:0] part;
        logic [7:0] b;
        int r;

        tick(5);
        check("rst_scan", 32'(scan_code), 0);
        check("rst_pulses", 32'({code_valid, frame_err}), 0);
        check("rst_keys", 32'({key_left, key_right, key_fire}), 0);
        reset = 1'b0;
        tick(20);

        // Space make, then break
        do_frame(8'h29, 1'b0, 1'b0);
        check("fire_set", 32'(key_fire), 1);
        do_frame(8'hF0, 1'b0, 1'b0);
        do_frame(8'h29, 1'b0, 1'b0);
        check("fire_clr", 32'(key_fire), 0);

        // Extended left arrow make/break; bare 6B must not touch it
        do_frame(8'hE0, 1'b0, 1'b0);
        do_frame(8'h6B, 1'b0, 1'b0);
        check("left_set", 32'(key_left), 1);
        do_frame(8'h6B, 1'b0, 1'b0);
        do_frame(8'hE0, 1'b0, 1'b0);
        do_frame(8'hF0, 1'b0, 1'b0);
        do_frame(8'h6B, 1'b0, 1'b0);
        check("left_clr", 32'({key_left, key_right}), 0);

        // Bad parity and bad stop
        do_frame(8'h74, 1'b1, 1'b0);
        check("badpar_scan", 32'(scan_code), 32'h6B);
        do_frame(8'h29, 1'b0, 1'b1);

        // Timeout after a prefix: flags cleared, then recovery
        do_frame(8'hE0, 1'b0, 1'b0);
        cv0 = cv_cnt; fe0 = fe_cnt;
        part = 11'($urandom) & 11'h7FE;
        send_bits(part, 4);
        tick(TO + 10);
        model_byte(8'h00, 1'b0);
        check("tout_fe", 32'(fe_cnt - fe0), 1);
        check("tout_cv", 32'(cv_cnt - cv0), 0);
        do_frame(8'h6B, 1'b0, 1'b0);
        do_frame(8'h5A, 1'b0, 1'b0);
        check("after_tout_scan", 32'(scan_code), 32'h5A);

        // Short low glitch that looks like a start bit
        cv0 = cv_cnt; fe0 = fe_cnt;
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(TO + 20);
        check("glitch_pulses", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 0);
        do_frame(8'h29, 1'b0, 1'b0);

        // Reset in the middle of DATA
        do_frame(8'hE0, 1'b0, 1'b0);
        do_frame(8'h74, 1'b0, 1'b0);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_bits(11'h0A4, 5);
        reset = 1'b1;
        tick(3);
        @(negedge clk);
        check("midrst_outs", 32'({scan_code, code_valid, frame_err, key_left, key_right, key_fire}), 0);
        tick(1);
        reset = 1'b0;
        reset_model();
        tick(TO + 20);
        check("midrst_pulses", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 0);
        do_frame(8'h29, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h29;
                3: b = 8'h6B;
                4: b = 8'h74;
                default: b = 8'($urandom);
            endcase
            r = $urandom_range(0, 9);
            do_frame(b, r == 0, r == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
